bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
Shares the single BRAM port A (16-bit address, 16-bit data, 1-cycle read latency) between two requesters.
- Requester 0: CPU memory controller, which handles A/M register traffic.
- Requester 1: video pixel fetch, which is real-time.
Arbitration is per cycle with fixed priority to requester 1 and a starvation guard for requester 0. Each read response returns to the requester that issued it.

Parameters:
ADDR_W, 16, address width.
DATA_W, 16, data width.
READ_LATENCY, 1, BRAM cycles from registered address to valid douta (range 1-3).
STARVE_MAX, 4, consecutive denied cycles of r0 before r0 is forced priority (range 1-255).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset.
r0_req  in  1  requester 0 access request; held until granted.
r0_we  in  1  requester 0 write (1) / read (0).
r0_addr  in  ADDR_W  requester 0 address.
r0_wdata  in  DATA_W  requester 0 write data.
r0_gnt  out  1  requester 0 grant; combinational, same cycle as req.
r0_rvalid  out  1  requester 0 read data valid; 1-cycle pulse.
r0_rdata  out  DATA_W  requester 0 read data.
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as r0_* for requester 1.
bram_addra  out  ADDR_W  registered BRAM address.
bram_dina  out  DATA_W  registered BRAM write data.
bram_wea  out  1  registered BRAM write enable.
bram_douta  in  DATA_W  BRAM read data.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst low clears all registered outputs: bram_addra=0, bram_dina=0, bram_wea=0, rvalid=0, rdata=0, starvation counter=0, read-return pipeline flushed.
  - Gnt outputs are 0 while rst is low.
- Arbitration (combinational):
  - If only one req is high, that requester is granted.
  - If both are high, r1 is granted, unless starve_cnt==STARVE_MAX, in which case r0 is granted.
  - At most one gnt is high per cycle.
- Starvation counter (8-bit, saturating at STARVE_MAX):
  - Increments when r0_req && !r0_gnt.
  - Clears when r0_gnt is high, or when r0_req is low.
- Issue: on the edge ending a granted cycle T:
  - bram_addra <= granted addr; bram_dina <= granted wdata; bram_wea <= granted we.
  - With no grant: bram_wea <= 0; addra and dina hold their previous values.
- Read return pipeline: a shift register of depth READ_LATENCY+1 carries {valid, id}.
  - A read granted at T sets bram_addra at T+1, and douta is valid at T+1+READ_LATENCY.
  - On the next edge, rdata for requester id <= douta and rvalid pulses. rvalid is visible at T+2+READ_LATENCY (T+3 by default).
  - The other requester's rdata holds its value; its rvalid stays 0.
- Writes produce no rvalid. Write-then-read to the same address on consecutive cycles returns the new data.
- Back-to-back grants are allowed every cycle. Reads from both requesters may be in flight at once, and return in issue order.
- Reset mid-operation: in-flight reads are discarded and never pulse rvalid. A bram_wea already registered is cleared asynchronously.
- Requesters must hold req/we/addr/wdata stable until gnt. Changes before gnt are legal and are sampled only in the grant cycle.

Optional Feature:
BRAM_ARB_STATS_EN
- Defined: adds outputs stat_grants0, stat_grants1, stat_conflicts (each 16-bit, wrap-around).
  - stat_grants0 / stat_grants1 count grants per requester.
  - stat_conflicts counts cycles with both req high.
  - All three reset to 0.
- Undefined: these ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, a requester-id type (1 bit, ID_CPU=0, ID_VID=1), and a read-tag type {valid, id}.
- One sub-module, bram_rd_return_pipe: a parameterised depth shift register of read tags plus the output demux to r0/r1 rdata/rvalid.

Test Plan:
- Reset mid-read: r0 read granted at T, rst low at T+1 for 1 cycle -> no r0_rvalid ever; all outputs 0 during reset.
- Single read: r0 read addr 0x0010 (mem=0xBEEF) granted at T -> bram_addra=0x0010 at T+1; r0_rvalid=1, r0_rdata=0xBEEF at T+3 only.
- Conflict: both req high with r0 read 0x0001 and r1 read 0x0002 -> r1_gnt=1 and r0_gnt=0. r1 data returns first; r0 is granted once r1 drops.
- Starvation: r1_req held high continuously, r0_req high, STARVE_MAX=4 -> r0 denied 4 cycles, granted on the 5th, then r1 resumes. Pattern repeats every 5 cycles.
- Write then read: r0 writes 0x1234 to 0x0100 at T, reads 0x0100 at T+1 -> bram_wea=1 only at T+1; r0_rdata=0x1234 at T+4.
- Interleaved reads: r1 read at T and r0 read at T+1 -> r1_rvalid at T+3 and r0_rvalid at T+4, with no cross-delivery.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
// Shared types for the BRAM port A arbiter: requester ids and read-return tags.
package bram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    ID_CPU = 1'b0,
    ID_VID = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, id: ID_CPU};

  function automatic rd_tag_t make_tag(input logic valid, input req_id_e id);
    rd_tag_t t;
    t.valid = valid;
    t.id    = id;
    return t;
  endfunction

endpackage

// File: rtl/bram_rd_return_pipe.sv
// Read-tag delay line matching the BRAM read path, plus the rdata/rvalid demux
// that hands each returning word to the requester that issued the read.
module bram_rd_return_pipe
  import bram_port_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  rd_tag_t           i_tag,
  input  logic [DATA_W-1:0] i_douta,
  output logic              o_r0_rvalid,
  output logic [DATA_W-1:0] o_r0_rdata,
  output logic              o_r1_rvalid,
  output logic [DATA_W-1:0] o_r1_rdata
);

  rd_tag_t           r_tags [DEPTH];
  logic              r_r0_rvalid;
  logic              r_r1_rvalid;
  logic [DATA_W-1:0] r_r0_rdata;
  logic [DATA_W-1:0] r_r1_rdata;
  rd_tag_t           w_tail;
  logic              w_hit0;
  logic              w_hit1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_tags[i] <= TAG_IDLE;
    end else begin
      r_tags[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_tags[i] <= r_tags[i-1];
    end
  end

  // The oldest tag lines up with the cycle in which douta holds its data.
  assign w_tail = r_tags[DEPTH-1];
  assign w_hit0 = w_tail.valid && (w_tail.id == ID_CPU);
  assign w_hit1 = w_tail.valid && (w_tail.id == ID_VID);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_r0_rvalid <= 1'b0;
      r_r1_rvalid <= 1'b0;
      r_r0_rdata  <= '0;
      r_r1_rdata  <= '0;
    end else begin
      r_r0_rvalid <= w_hit0;
      r_r1_rvalid <= w_hit1;
      if (w_hit0) r_r0_rdata <= i_douta;
      if (w_hit1) r_r1_rdata <= i_douta;
    end
  end

  assign o_r0_rvalid = r_r0_rvalid;
  assign o_r1_rvalid = r_r1_rvalid;
  assign o_r0_rdata  = r_r0_rdata;
  assign o_r1_rdata  = r_r1_rdata;

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for BRAM port A: video has priority, CPU is protected by a
// starvation guard. Optional statistics counters with `define BRAM_ARB_STATS_EN.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_MAX   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_wea,
  input  logic [DATA_W-1:0] bram_douta
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_grants0,
  output logic [15:0]       stat_grants1,
  output logic [15:0]       stat_conflicts
`endif
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]        r_starve_cnt;
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dina;
  logic              r_wea;

  logic              w_starved;
  logic              w_r0_gnt;
  logic              w_r1_gnt;
  logic              w_any_gnt;
  req_id_e           w_sel_id;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  rd_tag_t           w_tag;

  // Grants are forced low while reset is asserted so nothing is issued.
  always_comb begin
    w_starved = (r_starve_cnt == STARVE_LIM);
    w_r0_gnt  = 1'b0;
    w_r1_gnt  = 1'b0;
    if (rst) begin
      if (r0_req && (!r1_req || w_starved)) w_r0_gnt = 1'b1;
      else if (r1_req)                      w_r1_gnt = 1'b1;
    end
  end

  always_comb begin
    w_any_gnt   = w_r0_gnt || w_r1_gnt;
    w_sel_id    = ID_CPU;
    w_sel_we    = r0_we;
    w_sel_addr  = r0_addr;
    w_sel_wdata = r0_wdata;
    if (w_r1_gnt) begin
      w_sel_id    = ID_VID;
      w_sel_we    = r1_we;
      w_sel_addr  = r1_addr;
      w_sel_wdata = r1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (r0_req && !w_r0_gnt) begin
      if (r_starve_cnt != STARVE_LIM) r_starve_cnt <= r_starve_cnt + 8'd1;
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // Address and data only move on a grant; idle cycles just drop the write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addra <= '0;
      r_dina  <= '0;
      r_wea   <= 1'b0;
    end else begin
      r_wea <= w_any_gnt && w_sel_we;
      if (w_any_gnt) begin
        r_addra <= w_sel_addr;
        r_dina  <= w_sel_wdata;
      end
    end
  end

  assign w_tag = make_tag(w_any_gnt && !w_sel_we, w_sel_id);

  bram_rd_return_pipe #(
    .DEPTH  (READ_LATENCY + 1),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk         (clk),
    .rst         (rst),
    .i_tag       (w_tag),
    .i_douta     (bram_douta),
    .o_r0_rvalid (r0_rvalid),
    .o_r0_rdata  (r0_rdata),
    .o_r1_rvalid (r1_rvalid),
    .o_r1_rdata  (r1_rdata)
  );

  assign r0_gnt     = w_r0_gnt;
  assign r1_gnt     = w_r1_gnt;
  assign bram_addra = r_addra;
  assign bram_dina  = r_dina;
  assign bram_wea   = r_wea;

`ifdef BRAM_ARB_STATS_EN
  logic [15:0] r_stat_g0;
  logic [15:0] r_stat_g1;
  logic [15:0] r_stat_conf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_g0   <= '0;
      r_stat_g1   <= '0;
      r_stat_conf <= '0;
    end else begin
      if (w_r0_gnt)         r_stat_g0   <= r_stat_g0 + 16'd1;
      if (w_r1_gnt)         r_stat_g1   <= r_stat_g1 + 16'd1;
      if (r0_req && r1_req) r_stat_conf <= r_stat_conf + 16'd1;
    end
  end

  assign stat_grants0   = r_stat_g0;
  assign stat_grants1   = r_stat_g1;
  assign stat_conflicts = r_stat_conf;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: a BRAM model, a request-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_bram_port_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int RL   = 1;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina, bram_douta;
  logic          bram_wea;
`ifdef BRAM_ARB_STATS_EN
  logic [15:0]   statG0, statG1, statConf;
`endif

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  bram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
    .bram_douta(bram_douta)
`ifdef BRAM_ARB_STATS_EN
    , .stat_grants0(statG0), .stat_grants1(statG1), .stat_conflicts(statConf)
`endif
  );

  // Environment BRAM with RL cycles of read latency.
  logic [DW-1:0] bramMem [0:65535];
  logic [DW-1:0] doutPipe [RL];
  always @(posedge clk) begin
    if (bram_wea) bramMem[bram_addra] <= bram_dina;
    doutPipe[0] <= bramMem[bram_addra];
    for (int i = 1; i < RL; i++) doutPipe[i] <= doutPipe[i-1];
  end
  assign bram_douta = doutPipe[RL-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: what each requester is owed, tracked as pending returns.
  typedef struct {
    int            due;
    logic          id;
    logic [DW-1:0] data;
  } pend_t;

  logic [DW-1:0] modelMem [0:65535];
  pend_t         pend[$];
  pend_t         pe;
  int            starveCnt = 0;
  logic [AW-1:0] expAddra = '0;
  logic [DW-1:0] expDina = '0;
  logic          expWea = 1'b0;
  logic          expRv0 = 1'b0, expRv1 = 1'b0;
  logic [DW-1:0] expRd0 = '0, expRd1 = '0;
  logic          eg0, eg1, gWe;
  logic [AW-1:0] gAddr;
  logic [DW-1:0] gData;

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("rst_r0_gnt", r0_gnt, 0);
      checkOutput("rst_r1_gnt", r1_gnt, 0);
      checkOutput("rst_addra", bram_addra, 0);
      checkOutput("rst_dina", bram_dina, 0);
      checkOutput("rst_wea", bram_wea, 0);
      checkOutput("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
      checkOutput("rst_rdata", {r0_rdata, r1_rdata}, 0);
      pend.delete();
      starveCnt = 0;
      expAddra = '0; expDina = '0; expWea = 1'b0;
      expRv0 = 1'b0; expRv1 = 1'b0; expRd0 = '0; expRd1 = '0;
    end else begin
      eg0 = r0_req && (!r1_req || starveCnt == SMAX);
      eg1 = r1_req && !eg0;
      checkOutput("m_r0_gnt", r0_gnt, eg0);
      checkOutput("m_r1_gnt", r1_gnt, eg1);
      checkOutput("m_addra", bram_addra, expAddra);
      checkOutput("m_dina", bram_dina, expDina);
      checkOutput("m_wea", bram_wea, expWea);
      checkOutput("m_r0_rvalid", r0_rvalid, expRv0);
      checkOutput("m_r1_rvalid", r1_rvalid, expRv1);
      checkOutput("m_r0_rdata", r0_rdata, expRd0);
      checkOutput("m_r1_rdata", r1_rdata, expRd1);
      expWea = 1'b0;
      if (eg0 || eg1) begin
        gWe   = eg1 ? r1_we : r0_we;
        gAddr = eg1 ? r1_addr : r0_addr;
        gData = eg1 ? r1_wdata : r0_wdata;
        expAddra = gAddr;
        expDina  = gData;
        expWea   = gWe;
        if (gWe) modelMem[gAddr] = gData;
        else begin
          pe.due = cycle + 2 + RL; pe.id = eg1; pe.data = modelMem[gAddr];
          pend.push_back(pe);
        end
      end
      starveCnt = (r0_req && !eg0) ? starveCnt + 1 : 0;
      expRv0 = 1'b0;
      expRv1 = 1'b0;
      if (pend.size() > 0 && pend[0].due == cycle + 1) begin
        pe = pend.pop_front();
        if (pe.id) begin expRv1 = 1'b1; expRd1 = pe.data; end
        else       begin expRv0 = 1'b1; expRd0 = pe.data; end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic q0, input logic w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic q1, input logic w1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
  endtask

  typedef struct {
    logic q0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic q1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
  } vec_t;
  vec_t vecs[8];
  int   pulses;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      bramMem[i]  = 16'hC000 | 16'(i);
      modelMem[i] = 16'hC000 | 16'(i);
    end
    bramMem[16'h0010] = 16'hBEEF; modelMem[16'h0010] = 16'hBEEF;
    bramMem[16'h0001] = 16'h1111; modelMem[16'h0001] = 16'h1111;
    bramMem[16'h0002] = 16'h2222; modelMem[16'h0002] = 16'h2222;
    for (int i = 0; i < RL; i++) doutPipe[i] = '0;

    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step(3);
    rst = 1'b1;
    step(2);

    // Single read
    applyStimulus(1, 0, 16'h0010, 0, 0, 0, 0, 0);
    @(negedge clk); checkOutput("single_r0_gnt", r0_gnt, 1);
    step(1); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); checkOutput("single_addra", bram_addra, 16'h0010);
    step(1); @(negedge clk); checkOutput("single_early_rvalid", r0_rvalid, 0);
    step(1); @(negedge clk);
    checkOutput("single_rvalid", r0_rvalid, 1);
    checkOutput("single_rdata", r0_rdata, 16'hBEEF);
    step(1); @(negedge clk); checkOutput("single_pulse_end", r0_rvalid, 0);
    step(2);

    // Conflict: video wins, CPU follows once video drops
    applyStimulus(1, 0, 16'h0001, 0, 1, 0, 16'h0002, 0);
    @(negedge clk);
    checkOutput("conf_r1_gnt", r1_gnt, 1);
    checkOutput("conf_r0_gnt", r0_gnt, 0);
    step(1); applyStimulus(1, 0, 16'h0001, 0, 0, 0, 0, 0);
    @(negedge clk); checkOutput("conf_r0_gnt_later", r0_gnt, 1);
    step(1); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step(1); @(negedge clk);
    checkOutput("conf_r1_rvalid", r1_rvalid, 1);
    checkOutput("conf_r1_rdata", r1_rdata, 16'h2222);
    checkOutput("conf_r0_not_yet", r0_rvalid, 0);
    step(1); @(negedge clk);
    checkOutput("conf_r0_rvalid", r0_rvalid, 1);
    checkOutput("conf_r0_rdata", r0_rdata, 16'h1111);
    step(2);

    // Starvation guard: r0 wins every 5th cycle under continuous video load
    applyStimulus(1, 0, 16'h0003, 0, 1, 0, 16'h0004, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("starve_r0_gnt_%0d", i), r0_gnt, (i % 5 == 4));
      checkOutput($sformatf("starve_r1_gnt_%0d", i), r1_gnt, (i % 5 != 4));
      step(1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step(5);

    // Write then read the same address
    applyStimulus(1, 1, 16'h0100, 16'h1234, 0, 0, 0, 0);
    @(negedge clk); checkOutput("wr_gnt", r0_gnt, 1);
    step(1); applyStimulus(1, 0, 16'h0100, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wr_wea", bram_wea, 1);
    checkOutput("wr_dina", bram_dina, 16'h1234);
    step(1); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); checkOutput("wr_wea_drop", bram_wea, 0);
    step(2); @(negedge clk);
    checkOutput("wr_rd_rvalid", r0_rvalid, 1);
    checkOutput("wr_rd_rdata", r0_rdata, 16'h1234);
    step(2);

    // Interleaved reads
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0005, 0);
    step(1); applyStimulus(1, 0, 16'h0006, 0, 0, 0, 0, 0);
    step(1); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step(1); @(negedge clk);
    checkOutput("il_r1_rvalid", r1_rvalid, 1);
    checkOutput("il_r0_quiet", r0_rvalid, 0);
    checkOutput("il_r1_rdata", r1_rdata, 16'hC005);
    step(1); @(negedge clk);
    checkOutput("il_r0_rvalid", r0_rvalid, 1);
    checkOutput("il_r1_quiet", r1_rvalid, 0);
    checkOutput("il_r0_rdata", r0_rdata, 16'hC006);
    step(2);

    // Reset in the middle of a read
    applyStimulus(1, 0, 16'h0010, 0, 0, 0, 0, 0);
    step(1); rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_gnt", r0_gnt, 0);
    checkOutput("mid_rst_addra", bram_addra, 0);
    step(1); rst = 1'b1; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); if (r0_rvalid) pulses++;
      step(1);
    end
    checkOutput("mid_rst_no_rvalid", pulses, 0);

    // Mixed traffic table
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hA5A5};
    vecs[1] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0021, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'h0021, 16'h5A5A, 1'b1, 1'b0, 16'h0020, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 16'h0021, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0021, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].q0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                    vecs[i].q1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      step(1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
